// File: rtl/backup_pkg.sv
// Shared types and constants for the backup-RAM sector streamer.
package backup_pkg;

  typedef enum logic [1:0] {
    BK_IDLE = 2'd0,
    BK_REQ  = 2'd1,
    BK_XFER = 2'd2
  } bk_state_t;

  localparam int unsigned BK_SECTOR_BYTES = 512;

endpackage

// File: rtl/backup_sync_if.sv
// HPS SD sector request/acknowledge bundle between the streamer and hps_io.
interface backup_sync_if;

  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;

  modport master (output sd_lba, output sd_rd, output sd_wr, input sd_ack);
  modport slave  (input sd_lba, input sd_rd, input sd_wr, output sd_ack);

endinterface

// File: rtl/edge_rise.sv
// Single-signal edge detector; rise and fall both come from one delayed copy.
module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  // NOTE: clocked state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= 1'b0;
    else        sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/backup_sync.sv
// Backup-RAM sector streamer: sequences SECTORS load/save requests to the HPS,
// tracks NVRAM dirtiness, autosaves on OSD open and aborts stalled sectors.
module backup_sync
  import backup_pkg::*;
#(
  parameter int unsigned SECTORS  = 64,
  parameter int unsigned LBA_W    = 8,
  parameter logic [23:0] TIMEOUT  = 24'd5_000_000,
  parameter bit          AUTOSAVE = 1'b1
) (
  input  logic                 clk_sys,
  input  logic                 RESET_n,
  input  logic                 downloading,
  input  logic                 img_mounted,
  input  logic                 img_readonly,
  input  logic [63:0]          img_size,
  input  logic                 load_req,
  input  logic                 save_req,
  input  logic                 osd_open,
  input  logic                 nvram_we,
  backup_sync_if.master        sd,
  output logic                 ena,
  output logic                 busy,
  output logic                 loading,
  output logic                 dirty,
  output logic                 error
);

  logic load_rise, save_rise, osd_rise, ack_rise, dl_rise;
  logic ack_fall, dl_fall;
  logic load_fall_unused, save_fall_unused, osd_fall_unused;

  edge_rise u_load (.clk(clk_sys), .rst_n(RESET_n), .sig_i(load_req),    .rise_o(load_rise), .fall_o(load_fall_unused));
  edge_rise u_save (.clk(clk_sys), .rst_n(RESET_n), .sig_i(save_req),    .rise_o(save_rise), .fall_o(save_fall_unused));
  edge_rise u_osd  (.clk(clk_sys), .rst_n(RESET_n), .sig_i(osd_open),    .rise_o(osd_rise),  .fall_o(osd_fall_unused));
  edge_rise u_ack  (.clk(clk_sys), .rst_n(RESET_n), .sig_i(sd.sd_ack),   .rise_o(ack_rise),  .fall_o(ack_fall));
  edge_rise u_dl   (.clk(clk_sys), .rst_n(RESET_n), .sig_i(downloading), .rise_o(dl_rise),   .fall_o(dl_fall));

  bk_state_t        state_q, state_d;
  logic [LBA_W-1:0] lba_q, lba_d;
  logic [23:0]      wd_q, wd_d;
  logic             rd_q, rd_d, wr_q, wr_d;
  logic             ena_q, ena_d, busy_q, busy_d;
  logic             loading_q, loading_d, dirty_q, dirty_d, error_q, error_d;

  logic start_load, start_save, start_any, last_sector, wd_expire;

  // Load outranks save, so a simultaneous load/save edge only loads.
  assign start_load  = ena_q & (load_rise | (dl_fall & (img_size != 64'd0)));
  assign start_save  = ena_q & (save_rise | (AUTOSAVE & osd_rise & dirty_q));
  assign start_any   = start_load | start_save;
  assign last_sector = (lba_q == LBA_W'(SECTORS - 1));
  assign wd_expire   = (TIMEOUT != 24'd0) && (wd_q == TIMEOUT - 24'd1);

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q   <= BK_IDLE;
      lba_q     <= '0;
      wd_q      <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      ena_q     <= 1'b0;
      busy_q    <= 1'b0;
      loading_q <= 1'b0;
      dirty_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lba_q     <= lba_d;
      wd_q      <= wd_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      ena_q     <= ena_d;
      busy_q    <= busy_d;
      loading_q <= loading_d;
      dirty_q   <= dirty_d;
      error_q   <= error_d;
    end
  end

  // NOTE: every variable in a comb block gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BK_IDLE: if (start_any) state_d = BK_REQ;
      BK_REQ: begin
        if (ack_rise)       state_d = BK_XFER;
        else if (wd_expire) state_d = BK_IDLE;
      end
      BK_XFER: if (ack_fall) state_d = last_sector ? BK_IDLE : BK_REQ;
      default: state_d = BK_IDLE;
    endcase
  end

  always_comb begin
    lba_d     = lba_q;
    wd_d      = wd_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    loading_d = loading_q;
    dirty_d   = dirty_q;
    error_d   = error_q;
    ena_d     = ena_q;
    busy_d    = (state_d != BK_IDLE);

    if (dl_rise) ena_d = 1'b0;
    if (downloading & img_mounted & ~img_readonly) ena_d = 1'b1;

    unique case (state_q)
      BK_IDLE: begin
        if (start_any) begin
          lba_d     = '0;
          wd_d      = '0;
          rd_d      = start_load;
          wr_d      = ~start_load;
          loading_d = start_load;
          error_d   = 1'b0;
          if (!start_load) dirty_d = 1'b0;
        end
      end
      BK_REQ: begin
        if (ack_rise) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
        end else if (wd_expire) begin
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          loading_d = 1'b0;
          error_d   = 1'b1;
          // The image was never fully written, so the NVRAM is still unsaved.
          if (!loading_q) dirty_d = 1'b1;
        end else begin
          wd_d = wd_q + 24'd1;
        end
      end
      BK_XFER: begin
        if (ack_fall) begin
          if (last_sector) begin
            loading_d = 1'b0;
            if (loading_q) dirty_d = 1'b0;
          end else begin
            lba_d = lba_q + LBA_W'(1);
            wd_d  = '0;
            rd_d  = loading_q;
            wr_d  = ~loading_q;
          end
        end
      end
      default: ;
    endcase

    // A core write always wins over any clear landing in the same cycle.
    if (nvram_we) dirty_d = 1'b1;
  end

  assign sd.sd_lba = 32'(lba_q);
  assign sd.sd_rd  = rd_q;
  assign sd.sd_wr  = wr_q;
  assign ena       = ena_q;
  assign busy      = busy_q;
  assign loading   = loading_q;
  assign dirty     = dirty_q;
  assign error     = error_q;

endmodule
